// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data RAM port arbiter.
package mem_arb_pkg;
  localparam int ADDR_W         = 32;
  localparam int DATA_W         = 32;
  localparam int STRB_W         = 4;
  localparam int STREAK_MAX_DEF = 2;

  typedef enum logic {IDLE, WAIT} state_e;
  typedef enum logic {OWN_INST, OWN_DATA} owner_e;
endpackage

// File: rtl/mem_arb_grant.sv
// Priority decision: data first, unless it has already won STREAK_MAX grants
// in a row while a fetch was waiting.
module mem_arb_grant #(
  parameter int STREAK_MAX = 2
) (
  input  logic       inst_req_i,
  input  logic       data_req_i,
  input  logic [1:0] streak_i,
  input  logic       accept_i,
  output logic       grant_inst_o,
  output logic       grant_data_o
);
  logic starve;

  assign starve       = inst_req_i && (streak_i == 2'(STREAK_MAX));
  assign grant_data_o = accept_i && data_req_i && !starve;
  assign grant_inst_o = accept_i && inst_req_i && !grant_data_o;
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and data
// access, with one transaction in flight and a bounded data-priority streak.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RAM_LAT    = 1,
  parameter int STREAK_MAX = STREAK_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [STRB_W-1:0] data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              ram_en,
  output logic [STRB_W-1:0] ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  state_e     state_q, state_d;
  owner_e     owner_q, owner_d;
  logic [1:0] lat_cnt_q, lat_cnt_d;
  logic [1:0] streak_q, streak_d;
  logic       resp, accept, gnt_inst, gnt_data;

  assign resp   = (state_q == WAIT) && (lat_cnt_q == 2'd0);
  assign accept = (state_q == IDLE) || resp;

  mem_arb_grant #(.STREAK_MAX(STREAK_MAX)) u_grant (
    .inst_req_i   (inst_req),
    .data_req_i   (data_req),
    .streak_i     (streak_q),
    .accept_i     (accept),
    .grant_inst_o (gnt_inst),
    .grant_data_o (gnt_data)
  );

  // Every handshake output is gated by reset so the bus is quiet while held.
  assign inst_addr_ok = reset && gnt_inst;
  assign data_addr_ok = reset && gnt_data;
  assign inst_data_ok = reset && resp && (owner_q == OWN_INST);
  assign data_data_ok = reset && resp && (owner_q == OWN_DATA);
  assign inst_rdata   = inst_data_ok ? ram_rdata : '0;
  assign data_rdata   = data_data_ok ? ram_rdata : '0;

  assign ram_en    = inst_addr_ok || data_addr_ok;
  assign ram_addr  = data_addr_ok ? data_addr : (inst_addr_ok ? inst_addr : '0);
  assign ram_we    = (data_addr_ok && data_wr) ? data_wstrb : '0;
  assign ram_wdata = ram_en ? data_wdata : '0;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    lat_cnt_d = lat_cnt_q;
    streak_d  = streak_q;
    if (gnt_inst || gnt_data) begin
      state_d   = WAIT;
      owner_d   = gnt_data ? OWN_DATA : OWN_INST;
      lat_cnt_d = 2'(RAM_LAT - 1);
      if (gnt_data && inst_req)
        streak_d = (streak_q == 2'd3) ? streak_q : streak_q + 2'd1;
      else
        streak_d = 2'd0;
    end else if (state_q == WAIT) begin
      if (lat_cnt_q != 2'd0) lat_cnt_d = lat_cnt_q - 2'd1;
      else                   state_d   = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_INST;
      lat_cnt_q <= 2'd0;
      streak_q  <= 2'd0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      lat_cnt_q <= lat_cnt_d;
      streak_q  <= streak_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiters (RAM_LAT 1, 2, 3) share one stimulus bus.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, data_req, data_wr;
  logic [31:0] inst_addr, data_addr, data_wdata, ram_rdata;
  logic [3:0]  data_wstrb;

  logic        inst_addr_ok [3], inst_data_ok [3], data_addr_ok [3];
  logic        data_data_ok [3], ram_en [3];
  logic [31:0] inst_rdata [3], data_rdata [3], ram_addr [3], ram_wdata [3];
  logic [3:0]  ram_we [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter #(.RAM_LAT(g + 1), .STREAK_MAX(2)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok[g]),
      .inst_data_ok (inst_data_ok[g]),
      .inst_rdata   (inst_rdata[g]),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_wstrb   (data_wstrb),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok[g]),
      .data_data_ok (data_data_ok[g]),
      .data_rdata   (data_rdata[g]),
      .ram_en       (ram_en[g]),
      .ram_we       (ram_we[g]),
      .ram_addr     (ram_addr[g]),
      .ram_wdata    (ram_wdata[g]),
      .ram_rdata    (ram_rdata)
    );
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
  endtask

  task automatic idle(input int n);
    clr();
    repeat (n) tick();
  endtask

  task automatic test_reset;
    reset = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h1C00_0000;
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF;
    data_addr = 32'h80; data_wdata = 32'h5555_AAAA;
    tick(); #1;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({inst_addr_ok[g], inst_data_ok[g], data_addr_ok[g], data_data_ok[g], ram_en[g]} !== 5'b0) begin
        errors++;
        $display("FAIL reset_ok[%0d]: got %b%b%b%b%b want 00000", g, inst_addr_ok[g],
                 inst_data_ok[g], data_addr_ok[g], data_data_ok[g], ram_en[g]);
      end
      checks++;
      if ({ram_we[g], ram_addr[g], ram_wdata[g], inst_rdata[g], data_rdata[g]} !== '0) begin
        errors++;
        $display("FAIL reset_bus[%0d]: we=%h addr=%h wdata=%h ird=%h drd=%h want all 0", g,
                 ram_we[g], ram_addr[g], ram_wdata[g], inst_rdata[g], data_rdata[g]);
      end
    end
    clr();
    tick();
    reset = 1'b1;
    idle(2);
  endtask

  task automatic test_reset_mid_wait;
    tick();
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h200; #1;
    checks++;
    if (data_addr_ok[1] !== 1'b1) begin
      errors++; $display("FAIL midrst_accept: got %b want 1", data_addr_ok[1]);
    end
    tick();
    clr(); reset = 1'b0; #1;
    checks++;
    if ({data_data_ok[1], data_addr_ok[1], ram_en[1], data_rdata[1]} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: dok=%b aok=%b en=%b rd=%h want 0", data_data_ok[1],
               data_addr_ok[1], ram_en[1], data_rdata[1]);
    end
    tick();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (data_data_ok[1] !== 1'b0) begin
        errors++; $display("FAIL midrst_no_dok[%0d]: got %b want 0", k, data_data_ok[1]);
      end
      tick();
    end
  endtask

  task automatic test_single_inst;
    tick();
    inst_req = 1'b1; inst_addr = 32'h1C00_0000; #1;
    checks++;
    if ({inst_addr_ok[0], data_addr_ok[0], ram_en[0], ram_we[0]} !== 7'b1010000) begin
      errors++;
      $display("FAIL single_grant: iaok=%b daok=%b en=%b we=%h want 1 0 1 0", inst_addr_ok[0],
               data_addr_ok[0], ram_en[0], ram_we[0]);
    end
    checks++;
    if (ram_addr[0] !== 32'h1C00_0000) begin
      errors++; $display("FAIL single_addr: got %h want 1c000000", ram_addr[0]);
    end
    tick();
    inst_req = 1'b0; #1;
    checks++;
    if (inst_data_ok[0] !== 1'b1 || inst_rdata[0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_resp: dok=%b rdata=%h want 1 deadbeef", inst_data_ok[0], inst_rdata[0]);
    end
    checks++;
    if (data_data_ok[0] !== 1'b0 || data_rdata[0] !== 32'h0) begin
      errors++;
      $display("FAIL single_other: ddok=%b drdata=%h want 0 0", data_data_ok[0], data_rdata[0]);
    end
    tick(); #1;
    checks++;
    if (inst_data_ok[0] !== 1'b0 || inst_rdata[0] !== 32'h0) begin
      errors++;
      $display("FAIL single_once: dok=%b rdata=%h want 0 0", inst_data_ok[0], inst_rdata[0]);
    end
    idle(4);
  endtask

  task automatic test_write_vs_inst;
    tick();
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
    data_addr = 32'h100; data_wdata = 32'h1234_5678;
    inst_req = 1'b1; inst_addr = 32'h1C00_0004; #1;
    checks++;
    if (data_addr_ok[0] !== 1'b1 || inst_addr_ok[0] !== 1'b0) begin
      errors++;
      $display("FAIL wr_prio: daok=%b iaok=%b want 1 0", data_addr_ok[0], inst_addr_ok[0]);
    end
    checks++;
    if (ram_we[0] !== 4'b0011 || ram_addr[0] !== 32'h100 || ram_wdata[0] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL wr_bus: we=%b addr=%h wdata=%h want 0011 100 12345678", ram_we[0],
               ram_addr[0], ram_wdata[0]);
    end
    tick();
    data_req = 1'b0; data_wr = 1'b0; #1;
    checks++;
    if ({inst_addr_ok[0], data_data_ok[0], inst_data_ok[0], ram_we[0]} !== 7'b1100000) begin
      errors++;
      $display("FAIL wr_t1: iaok=%b ddok=%b idok=%b we=%b want 1 1 0 0000", inst_addr_ok[0],
               data_data_ok[0], inst_data_ok[0], ram_we[0]);
    end
    checks++;
    if (ram_addr[0] !== 32'h1C00_0004) begin
      errors++; $display("FAIL wr_t1_addr: got %h want 1c000004", ram_addr[0]);
    end
    tick();
    inst_req = 1'b0; #1;
    checks++;
    if (inst_data_ok[0] !== 1'b1 || data_data_ok[0] !== 1'b0) begin
      errors++;
      $display("FAIL wr_t2: idok=%b ddok=%b want 1 0", inst_data_ok[0], data_data_ok[0]);
    end
    idle(4);
  endtask

  task automatic test_streak;
    logic [5:0] exp_d;
    exp_d = 6'b011011;  // bit k: 1 = data wins cycle k (D,D,I,D,D,I)
    tick();
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h300;
    inst_req = 1'b1; inst_addr = 32'h1C00_0008;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if (data_addr_ok[0] !== exp_d[k] || inst_addr_ok[0] !== !exp_d[k]) begin
        errors++;
        $display("FAIL streak[%0d]: daok=%b iaok=%b want %b %b", k, data_addr_ok[0],
                 inst_addr_ok[0], exp_d[k], !exp_d[k]);
      end
      tick();
    end
    idle(5);
  endtask

  task automatic test_lat3;
    logic [9:0] exp_acc, exp_dok;
    exp_acc = 10'b0001001001;  // accepts at T, T+3, T+6
    exp_dok = 10'b1001001000;  // responses at T+3, T+6, T+9
    inst_addr = 32'h1C00_0010;
    for (int k = 0; k < 10; k++) begin
      inst_req = (k <= 6); #1;
      checks++;
      if (inst_addr_ok[2] !== exp_acc[k] || ram_en[2] !== exp_acc[k] ||
          inst_data_ok[2] !== exp_dok[k]) begin
        errors++;
        $display("FAIL lat3[%0d]: iaok=%b en=%b idok=%b want %b %b %b", k, inst_addr_ok[2],
                 ram_en[2], inst_data_ok[2], exp_acc[k], exp_acc[k], exp_dok[k]);
      end
      tick();
    end
    idle(4);
  endtask

  task automatic test_wstrb_zero;
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'h0;
    data_addr = 32'h40; data_wdata = 32'hAAAA_5555; #1;
    checks++;
    if (data_addr_ok[0] !== 1'b1 || ram_en[0] !== 1'b1 || ram_we[0] !== 4'h0) begin
      errors++;
      $display("FAIL wz_l1: daok=%b en=%b we=%b want 1 1 0000", data_addr_ok[0], ram_en[0], ram_we[0]);
    end
    checks++;
    if (data_addr_ok[2] !== 1'b1 || ram_we[2] !== 4'h0 || ram_addr[2] !== 32'h40) begin
      errors++;
      $display("FAIL wz_l3: daok=%b we=%b addr=%h want 1 0000 40", data_addr_ok[2], ram_we[2], ram_addr[2]);
    end
    tick();
    clr();
    for (int k = 1; k <= 3; k++) begin
      #1;
      checks++;
      if (data_data_ok[0] !== (k == 1) || data_data_ok[2] !== (k == 3)) begin
        errors++;
        $display("FAIL wz_dok[T+%0d]: l1=%b l3=%b want %b %b", k, data_data_ok[0],
                 data_data_ok[2], (k == 1), (k == 3));
      end
      tick();
    end
    idle(2);
  endtask

  initial begin
    reset = 1'b0;
    inst_addr = '0; data_addr = '0; data_wdata = '0;
    ram_rdata = 32'hDEAD_BEEF;
    clr();
    test_reset();
    test_reset_mid_wait();
    test_single_inst();
    test_write_vs_inst();
    test_streak();
    test_lat3();
    test_wstrb_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between the IF-stage instruction fetch and the EXE-stage data access.
- Both requesters use a req / addr_ok / data_ok handshake.
- At most one transaction is outstanding on the RAM. Data wins over instruction, with a bounded anti-starvation rule.
- Sits between the pipeline stages and the RAM, replacing their direct RAM connections.

Parameters:
- RAM_LAT, 1, RAM read latency in cycles from the en/addr cycle to valid ram_rdata; legal range 1..4.
- STREAK_MAX, 2, maximum consecutive data grants while inst_req is pending.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- inst_req  in  1  fetch request; held with inst_addr until inst_addr_ok
- inst_addr  in  32  fetch address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch data valid this cycle
- inst_rdata  out  32  fetch data; equals ram_rdata when inst_data_ok, else 0
- data_req  in  1  data request; held with all data_* inputs until data_addr_ok
- data_wr  in  1  1 = write, 0 = read
- data_wstrb  in  4  byte write strobes
- data_addr  in  32  data address
- data_wdata  in  32  write data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  data response this cycle (reads and writes)
- data_rdata  out  32  read data; equals ram_rdata when data_data_ok, else 0
- ram_en  out  1  RAM enable
- ram_we  out  4  RAM byte write enables
- ram_addr  out  32  RAM address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data

Behaviour:
- States: IDLE, WAIT. Registers: state, owner (INST/DATA), lat_cnt (2 bit), streak (2 bit).
- Reset (asynchronous, while reset=0):
  - state=IDLE, lat_cnt=0, streak=0.
  - All *_ok=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, rdata outputs=0.
  - An in-flight transaction is dropped; no data_ok is ever issued for it.
- Accept window: the cycle where state=IDLE, or state=WAIT with lat_cnt=0.
- Grant (combinational, accept window only):
  - If data_req and not (inst_req and streak==STREAK_MAX), grant DATA.
  - Else if inst_req, grant INST.
  - Else no grant.
- In the grant cycle (combinational):
  - Winner's addr_ok=1.
  - ram_en=1, ram_addr = winner's address.
  - ram_we = data_wstrb if DATA and data_wr, else 0.
  - ram_wdata = data_wdata.
  - Loser's addr_ok=0.
- On a grant: owner is set to the winner, lat_cnt=RAM_LAT-1, state=WAIT.
- Streak update on a grant:
  - DATA grant with inst_req=1: streak++ (saturating).
  - INST grant, or DATA grant with inst_req=0: streak=0.
- In WAIT with lat_cnt!=0: lat_cnt decrements, no grant, ram_en=0.
- In WAIT with lat_cnt==0:
  - Owner's data_ok=1 for exactly one cycle.
  - Owner's rdata=ram_rdata. Writes also get data_ok; the rdata value is don't-care but still ram_rdata.
  - The same cycle is an accept window. On a new grant, stay in WAIT; otherwise go to IDLE.
- Latency: a request accepted at cycle T gets data_ok at T+RAM_LAT.
- Throughput: with RAM_LAT=1, one transaction per cycle back-to-back. In general, one per RAM_LAT cycles.
- Simultaneous inst_req and data_req: DATA wins unless the streak limit is reached.
- data_wr=1 with data_wstrb=0: no RAM write, data_ok still returned.
- Requests that drop before addr_ok are legal and simply ignored.
- Requester is absent in a cycle: that requester's addr_ok and data_ok are never asserted.
- Invariant: never both addr_ok in one cycle, never both data_ok in one cycle.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding (IDLE, WAIT)
  - owner encoding (OWN_INST, OWN_DATA)
  - STREAK_MAX default
  - bus width constants (32 address / data, 4 strobes)
- One sub-module, mem_arb_grant: combinational priority plus streak decision. Inputs: inst_req, data_req, streak, accept window. Outputs: grant_inst, grant_data.

Test Plan:
- Reset asserted mid-WAIT (RAM_LAT=2, read issued at T, reset at T+1): all outputs 0 immediately; no data_ok after reset is released.
- Single inst_req at address 0x1C00_0000, RAM_LAT=1: inst_addr_ok at T, ram_en=1, ram_addr=0x1C00_0000; inst_data_ok at T+1 with inst_rdata=ram_rdata (0xDEAD_BEEF).
- Data write (addr 0x100, wdata 0x1234_5678, wstrb 4'b0011) simultaneous with inst_req: data_addr_ok at T with ram_we=4'b0011; inst_addr_ok at T+1; data_data_ok at T+1; inst_data_ok at T+2.
- Continuous data_req and inst_req for 6 cycles, RAM_LAT=1: grant order D,D,I,D,D,I; no cycle with both addr_ok.
- RAM_LAT=3, back-to-back inst reads: accepts at T, T+3, T+6; inst_data_ok at T+3, T+6, T+9; ram_en=0 at T+1 and T+2.
- data_wr=1 with wstrb=0 at addr 0x40: ram_we=0 and data_data_ok at T+RAM_LAT; RAM contents unchanged.
